// File: rtl/rv_pkg.sv
// Shared definitions for the multicycle RISC-V datapath: opcodes, ALU ops, FSM states
// and the funct3/funct7 to ALU-op decoder.
package rv_pkg;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_LW = 7'b0000011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_e;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
  } state_e;

  typedef struct packed {
    alu_op_e op;
    logic    legal;
  } alu_sel_t;

  // alt is instr[30]: funct7[5] for R-type, imm[10] for I-type shifts.
  function automatic alu_sel_t alu_decode(input logic [2:0] funct3, input logic alt,
                                          input logic is_r);
    alu_sel_t sel;
    sel.op    = ALU_ADD;
    sel.legal = 1'b1;
    case (funct3)
      3'b000:  sel.op = (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  sel.op = ALU_SLL;
      3'b010:  sel.op = ALU_SLT;
      3'b100:  sel.op = ALU_XOR;
      3'b101:  sel.op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  sel.op = ALU_OR;
      3'b111:  sel.op = ALU_AND;
      default: sel.legal = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/rv_alu.sv
// Combinational XLEN-wide ALU; zero flag drives branch resolution.
module rv_alu
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL: result = a << shamt;
      ALU_SRL: result = a >> shamt;
      ALU_SRA: result = $signed(a) >>> shamt;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rv_multicycle_datapath.sv
// Multicycle RV32/64 subset core (R/I ALU, LW, SW, BEQ, BNE) with valid/ready memories.
// state     | meaning
// FETCH     | request IR from imem at PC
// DECODE    | read operands, build immediate, trap illegal opcodes
// EXECUTE   | ALU op, address calc or branch resolve
// MEM       | data load/store handshake
// WRITEBACK | write rd, advance PC
// HALT      | terminal until reset
module rv_multicycle_datapath
  import rv_pkg::*;
#(
  parameter int          XLEN       = 32,
  parameter int          NREGS      = 32,
  parameter logic [31:0] INITIAL_PC = 32'h00400000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            halted
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_e          state, state_next;
  logic [31:0]     ir;
  logic [XLEN-1:0] a, b, imm, alu_out, mdr;
  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] op2, alu_result, pc_next, imm_dec;
  logic [11:0]     imm12;
  logic            alu_zero, complete, illegal, opcode_legal;
  alu_op_e         alu_op;
  alu_sel_t        sel;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [AW-1:0]   rs1, rs2, rd;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign rs1    = ir[15 +: AW];
  assign rs2    = ir[20 +: AW];
  assign rd     = ir[7 +: AW];
  assign sel    = alu_decode(funct3, ir[30], opcode == OP_R);
  assign opcode_legal = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_S) ||
                        (opcode == OP_B) || (opcode == OP_LW);

  always_comb begin
    imm12 = '0;
    case (opcode)
      OP_I, OP_LW: imm12 = ir[31:20];
      OP_S:        imm12 = {ir[31:25], ir[11:7]};
      OP_B:        imm12 = {ir[31], ir[7], ir[30:25], ir[11:8]};
      default:     imm12 = '0;
    endcase
  end
  assign imm_dec = {{(XLEN-12){imm12[11]}}, imm12};

  // ALU controls depend only on IR, so they never loop through the FSM's zero test.
  always_comb begin
    alu_op = ALU_ADD;
    op2    = imm;
    if (opcode == OP_R || opcode == OP_B) op2 = b;
    if (opcode == OP_B) alu_op = ALU_SUB;
    else if (opcode == OP_R || opcode == OP_I) alu_op = sel.op;
  end

  rv_alu #(.XLEN(XLEN)) u_alu (
    .a      (a),
    .b      (op2),
    .op     (alu_op),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    complete   = 1'b0;
    illegal    = 1'b0;
    pc_next    = pc + XLEN'(4);
    case (state)
      S_FETCH: if (imem_ready) state_next = S_DECODE;
      S_DECODE: begin
        if (opcode_legal) state_next = S_EXECUTE;
        else begin
          illegal    = 1'b1;
          state_next = S_HALT;
        end
      end
      S_EXECUTE: begin
        case (opcode)
          OP_R, OP_I: begin
            if (sel.legal) state_next = S_WRITEBACK;
            else begin
              illegal    = 1'b1;
              state_next = S_HALT;
            end
          end
          OP_LW, OP_S: state_next = S_MEM;
          OP_B: begin
            if (funct3 == 3'b000 || funct3 == 3'b001) begin
              complete   = 1'b1;
              state_next = S_FETCH;
              // funct3[0] inverts the equality test for BNE
              if (alu_zero ^ funct3[0]) pc_next = pc + {imm[XLEN-2:0], 1'b0};
            end else begin
              illegal    = 1'b1;
              state_next = S_HALT;
            end
          end
          default: begin
            illegal    = 1'b1;
            state_next = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          complete   = (opcode == OP_S);
          state_next = (opcode == OP_S) ? S_FETCH : S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        complete   = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_FETCH;
    endcase
  end

  // Requests are gated by rst so an in-flight handshake is dropped the instant reset asserts.
  assign imem_req   = rst && (state == S_FETCH);
  assign imem_addr  = pc;
  assign dmem_req   = rst && (state == S_MEM);
  assign dmem_we    = dmem_req && (opcode == OP_S);
  assign dmem_addr  = alu_out;
  assign dmem_wdata = b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      imm     <= '0;
      alu_out <= '0;
      mdr     <= '0;
      pc      <= XLEN'(INITIAL_PC);
      retire  <= 1'b0;
      halted  <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      retire <= complete;
      if (illegal) halted <= 1'b1;
      if (complete) pc <= pc_next;
      case (state)
        S_FETCH:  if (imem_ready) ir <= imem_rdata;
        S_DECODE: begin
          a   <= regs[rs1];
          b   <= regs[rs2];
          imm <= imm_dec;
        end
        S_EXECUTE: alu_out <= alu_result;
        S_MEM:     if (dmem_ready && opcode == OP_LW) mdr <= dmem_rdata;
        S_WRITEBACK: begin
          if (rd != '0) regs[rd] <= (opcode == OP_LW) ? mdr : alu_out;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_multicycle_datapath.sv
// Directed bench: a 32-bit core and a 64-bit/16-register core sharing clock and reset.
module tb_rv_multicycle_datapath;

  localparam logic [31:0] BASE = 32'h00400000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        imem_req32, imem_ready32, dmem_req32, dmem_we32, dmem_ready32, retire32, halted32;
  logic [31:0] imem_addr32, imem_rdata32, dmem_addr32, dmem_wdata32, dmem_rdata32, pc32;
  logic        imem_req64, imem_ready64, dmem_req64, dmem_we64, dmem_ready64, retire64, halted64;
  logic [31:0] imem_rdata64;
  logic [63:0] imem_addr64, dmem_addr64, dmem_wdata64, dmem_rdata64, pc64;

  logic [31:0] imem32 [32];
  logic [31:0] imem64 [32];
  logic [31:0] dmem32 [32];

  assign imem_rdata32 = imem32[imem_addr32[6:2]];
  assign dmem_rdata32 = dmem32[dmem_addr32[6:2]];
  assign imem_rdata64 = imem64[imem_addr64[6:2]];
  assign dmem_rdata64 = '0;

  rv_multicycle_datapath dut32 (
    .clk(clk), .rst(rst),
    .imem_req(imem_req32), .imem_addr(imem_addr32), .imem_ready(imem_ready32),
    .imem_rdata(imem_rdata32),
    .dmem_req(dmem_req32), .dmem_we(dmem_we32), .dmem_addr(dmem_addr32),
    .dmem_wdata(dmem_wdata32), .dmem_ready(dmem_ready32), .dmem_rdata(dmem_rdata32),
    .pc(pc32), .retire(retire32), .halted(halted32)
  );

  rv_multicycle_datapath #(.XLEN(64), .NREGS(16)) dut64 (
    .clk(clk), .rst(rst),
    .imem_req(imem_req64), .imem_addr(imem_addr64), .imem_ready(imem_ready64),
    .imem_rdata(imem_rdata64),
    .dmem_req(dmem_req64), .dmem_we(dmem_we64), .dmem_addr(dmem_addr64),
    .dmem_wdata(dmem_wdata64), .dmem_ready(dmem_ready64), .dmem_rdata(dmem_rdata64),
    .pc(pc64), .retire(retire64), .halted(halted64)
  );

  int          st_cnt32 = 0;
  int          st_cnt64 = 0;
  logic [63:0] st_addr32, st_data32, st_addr64, st_data64;

  always @(posedge clk) begin
    if (dmem_req32 && dmem_ready32 && dmem_we32) begin
      dmem32[dmem_addr32[6:2]] <= dmem_wdata32;
      st_cnt32  <= st_cnt32 + 1;
      st_addr32 <= 64'(dmem_addr32);
      st_data32 <= 64'(dmem_wdata32);
    end
    if (dmem_req64 && dmem_ready64 && dmem_we64) begin
      st_cnt64  <= st_cnt64 + 1;
      st_addr64 <= dmem_addr64;
      st_data64 <= dmem_wdata64;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic wait_store(input bit wide, input int budget, output logic [63:0] addr,
                            output logic [63:0] data, output bit ok);
    int start;
    start = wide ? st_cnt64 : st_cnt32;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if ((wide ? st_cnt64 : st_cnt32) != start) ok = 1'b1;
    end
    addr = wide ? st_addr64 : st_addr32;
    data = wide ? st_data64 : st_data32;
  endtask

  task automatic wait_halt(input bit wide, input int budget, output int retires, output bit ok);
    retires = 0;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      #1;
      if (wide ? retire64 : retire32) retires++;
      if (wide ? halted64 : halted32) ok = 1'b1;
    end
  endtask

  task automatic store_step(input string tag, input bit wide, input logic [63:0] exp_addr,
                            input logic [63:0] exp_data);
    logic [63:0] sa, sd;
    bit ok;
    wait_store(wide, 30, sa, sd, ok);
    check({tag, "_seen"}, 64'(ok), 64'd1);
    check({tag, "_addr"}, sa, exp_addr);
    check({tag, "_data"}, sd, exp_data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  n;
    int  rets;
    bit  ok;

    imem_ready32 = 1'b1;
    dmem_ready32 = 1'b0;
    imem_ready64 = 1'b1;
    dmem_ready64 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      imem32[i] = 32'h0000007F;
      imem64[i] = 32'h0000007F;
    end
    imem32[0]  = 32'h00500093;  // addi x1,x0,5
    imem32[1]  = 32'h00700113;  // addi x2,x0,7
    imem32[2]  = 32'h002081B3;  // add  x3,x1,x2
    imem32[3]  = 32'h00302423;  // sw   x3,8(x0)
    imem32[4]  = 32'h00802203;  // lw   x4,8(x0)
    imem32[5]  = 32'h00402623;  // sw   x4,12(x0)
    imem32[6]  = 32'h00500013;  // addi x0,x0,5
    imem32[7]  = 32'h00002823;  // sw   x0,16(x0)
    imem32[8]  = 32'h403082B3;  // sub  x5,x1,x3
    imem32[9]  = 32'h00502A23;  // sw   x5,20(x0)
    imem64[0]  = 32'hFFF00093;  // addi x1,x0,-1
    imem64[1]  = 32'h43F0D113;  // srai x2,x1,63
    imem64[2]  = 32'h00102023;  // sw   x1,0(x0)
    imem64[3]  = 32'h00202423;  // sw   x2,8(x0)
    imem64[4]  = 32'h00300893;  // addi x17,x0,3  (aliases x1)
    imem64[5]  = 32'h00102823;  // sw   x1,16(x0)

    repeat (2) @(negedge clk);
    check("rst_pc32", 64'(pc32), 64'(BASE));
    check("rst_pc64", pc64, 64'(BASE));
    check("rst_imem_req", 64'(imem_req32), 64'd0);
    check("rst_dmem_req", 64'(dmem_req32), 64'd0);
    check("rst_retire", 64'(retire32), 64'd0);
    check("rst_halted", 64'(halted32), 64'd0);

    @(negedge clk);
    rst = 1'b1;
    n = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (retire32) n++;
    end
    check("alu3_retires", 64'(n), 64'd3);
    check("alu3_pc", 64'(pc32), 64'h0040000C);

    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (dmem_req32) ok = 1'b1;
    end
    check("sw_req_seen", 64'(ok), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sw_hold%0d_ctl", i), {30'd0, dmem_req32, dmem_we32, dmem_addr32},
            {30'd0, 1'b1, 1'b1, 32'd8});
      check($sformatf("sw_hold%0d_wdata", i), 64'(dmem_wdata32), 64'd12);
      if (i < 3) @(negedge clk);
      else dmem_ready32 = 1'b1;
    end
    @(posedge clk);
    #1;
    check("sw_retire", 64'(retire32), 64'd1);
    check("sw_pc", 64'(pc32), 64'h00400010);

    store_step("lw_x4", 1'b0, 64'd12, 64'd12);
    store_step("x0_zero", 1'b0, 64'd16, 64'd0);
    store_step("sub_neg", 1'b0, 64'd20, 64'h00000000FFFFFFF9);

    wait_halt(1'b0, 20, rets, ok);
    check("halt_seen", 64'(ok), 64'd1);
    check("halt_no_retire", 64'(rets), 64'd0);
    check("halt_pc", 64'(pc32), 64'h00400028);
    n = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (imem_req32 || retire32) n++;
    end
    check("halt_quiet", 64'(n), 64'd0);
    check("halt_sticky", 64'(halted32), 64'd1);

    rst = 1'b0;
    imem32[0] = 32'h00000463;  // beq x0,x0,+8
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("beq_pc", 64'(pc32), 64'h00400008);
    check("beq_retire", 64'(retire32), 64'd1);
    @(posedge clk);
    #1;
    check("beq_retire_once", 64'(retire32), 64'd0);

    rst = 1'b0;
    imem32[0] = 32'h00001463;  // bne x0,x0,+8
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bne_pc", 64'(pc32), 64'h00400004);
    check("bne_retire", 64'(retire32), 64'd1);

    rst = 1'b0;
    imem32[0] = 32'h00302423;  // sw x3,8(x0), held off by dmem_ready=0
    dmem_ready32 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (dmem_req32) ok = 1'b1;
    end
    check("midmem_req_seen", 64'(ok), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("midmem_dmem_drop", 64'(dmem_req32), 64'd0);
    check("midmem_imem_low", 64'(imem_req32), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midmem_refetch_req", 64'(imem_req32), 64'd1);
    check("midmem_refetch_addr", 64'(imem_addr32), 64'(BASE));

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    store_step("x64_neg1", 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    store_step("x64_srai63", 1'b1, 64'd8, 64'hFFFF_FFFF_FFFF_FFFF);
    store_step("x64_alias", 1'b1, 64'd16, 64'd3);
    wait_halt(1'b1, 20, rets, ok);
    check("x64_halt_seen", 64'(ok), 64'd1);
    check("x64_halt_pc", pc64, 64'h0000_0000_0040_0018);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
